// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit path.
//   - arb_state_e : arbiter FSM encoding (ARB/FETCH/STROBE/GUARD/DRAIN)
//   - PAYLOAD_BITS_DEF, CLK_HZ, BIT_RATE : defaults shared with uart_rx/uart_tx
//   - clog2_min1() : counter width helper that never returns 0
package uart_tx_arbiter_pkg;

  localparam int unsigned PAYLOAD_BITS_DEF = 8;
  localparam int unsigned CLK_HZ           = 100_000_000;
  localparam int unsigned BIT_RATE         = 115_200;

  typedef enum logic [2:0] {
    ST_ARB    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_STROBE = 3'd2,
    ST_GUARD  = 3'd3,
    ST_DRAIN  = 3'd4
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   ptr_i  : index with highest priority; priority falls off upward with wrap
//   pick_o : one-hot winner (zero when no request)
//   any_o  : at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             any_o
);

  assign any_o = |req_i;

  // Pick the requester at the smallest wrapped distance from ptr_i.
  // Pointer values >= N_REQ (non power-of-two N_REQ) fold back by modulo.
  always_comb begin
    int d;
    int best;
    int best_i;
    d      = 0;
    best   = int'(N_REQ);
    best_i = 0;
    pick_o = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      d = (i + int'(N_REQ) - (int'(ptr_i) % int'(N_REQ))) % int'(N_REQ);
      if (req_i[i] && (d < best)) begin
        best   = d;
        best_i = i;
      end
    end
    for (int i = 0; i < int'(N_REQ); i++)
      pick_o[i] = (best != int'(N_REQ)) && (best_i == i);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte streams. Grants are
// round-robin at packet granularity: the owner keeps the grant until it
// delivers a byte flagged last, or until it leaves FETCH idle for
// TIMEOUT_CYCLES cycles.
// Ports:
//   clk_i, reset_i         : clock, synchronous active-high reset
//   req_valid_i/req_data_i/req_last_i/req_ready_o : per-requester byte streams
//   uart_tx_en_o           : one-cycle start strobe to uart_tx
//   uart_tx_data_o         : registered byte to uart_tx
//   uart_tx_busy_i         : uart_tx serializing
//   grant_o                : one-hot owner, zero when idle
//   timeout_pulse_o        : one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned PAYLOAD_BITS   = PAYLOAD_BITS_DEF,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data_i,
  input  logic [N_REQ-1:0]              req_last_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic                          uart_tx_en_o,
  output logic [PAYLOAD_BITS-1:0]       uart_tx_data_o,
  input  logic                          uart_tx_busy_i,
  output logic [N_REQ-1:0]              grant_o,
  output logic                          timeout_pulse_o
);

  localparam int unsigned PTR_W   = clog2_min1(N_REQ);
  localparam int unsigned TO_W    = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int unsigned GD_W    = clog2_min1(GUARD_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned GD_LAST = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;

  arb_state_e              state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        gidx_q, gidx_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [GD_W-1:0]         gd_cnt_q, gd_cnt_d;
  logic                    to_pulse_q, to_pulse_d;

  logic [N_REQ-1:0]        pick;
  logic                    any_req;
  logic [PTR_W-1:0]        pick_idx;
  logic [PTR_W-1:0]        ptr_next;
  logic                    sel_valid;
  logic                    sel_last;
  logic [PAYLOAD_BITS-1:0] sel_data;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .pick_o(pick),
    .any_o (any_req)
  );

  // Granted lane's handshake signals; grant_q is one-hot or zero.
  always_comb begin
    sel_valid = |(req_valid_i & grant_q);
    sel_last  = |(req_last_i & grant_q);
    sel_data  = '0;
    pick_idx  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q[i]) sel_data = req_data_i[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      if (pick[i])    pick_idx = PTR_W'(i);
    end
  end

  // Priority moves to the lane after the one that just released.
  assign ptr_next = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    data_d     = data_q;
    last_d     = last_q;
    to_cnt_d   = to_cnt_q;
    gd_cnt_d   = gd_cnt_q;
    to_pulse_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (any_req) begin
          grant_d  = pick;
          gidx_d   = pick_idx;
          to_cnt_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A byte arriving on the expiry cycle takes precedence over timeout.
        if (sel_valid) begin
          data_d   = sel_data;
          last_d   = sel_last;
          to_cnt_d = '0;
          state_d  = ST_STROBE;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_W'(TO_LAST))) begin
          to_pulse_d = 1'b1;
          grant_d    = '0;
          ptr_d      = ptr_next;
          to_cnt_d   = '0;
          state_d    = ST_ARB;
        end else if (TIMEOUT_CYCLES != 0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_STROBE: begin
        gd_cnt_d = '0;
        state_d  = ST_GUARD;
      end
      ST_GUARD: begin
        // uart_tx needs a couple of cycles to raise busy; ignore it here.
        if (gd_cnt_q == GD_W'(GD_LAST)) state_d = ST_DRAIN;
        else                            gd_cnt_d = gd_cnt_q + 1'b1;
      end
      ST_DRAIN: begin
        if (!uart_tx_busy_i) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = ptr_next;
            state_d = ST_ARB;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      to_cnt_q   <= '0;
      gd_cnt_q   <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      last_q     <= last_d;
      to_cnt_q   <= to_cnt_d;
      gd_cnt_q   <= gd_cnt_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  assign req_ready_o     = (state_q == ST_FETCH) ? grant_q : '0;
  assign uart_tx_en_o    = (state_q == ST_STROBE);
  assign uart_tx_data_o  = data_q;
  assign grant_o         = grant_q;
  assign timeout_pulse_o = to_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart_tx busy model
// (busy rises 2 cycles after en and stays high for BUSY_LEN cycles).
module tb_uart_tx_arbiter;

  localparam int PB       = 8;
  localparam int TMO      = 50;
  localparam int BUSY_LEN = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_last = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        timeout_pulse;
  logic        busy = 1'b0;
  logic        en_d1 = 1'b0;
  int          bcnt = 0;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] txlog[$];
  logic [7:0] hold = '0;
  bit         hold_ok = 1'b0;
  bit         busy_prev = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(2), .PAYLOAD_BITS(PB), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .uart_tx_en_o   (uart_tx_en),
    .uart_tx_data_o (uart_tx_data),
    .uart_tx_busy_i (busy),
    .grant_o        (grant),
    .timeout_pulse_o(timeout_pulse)
  );

  // uart_tx model; not reset, so a frame in flight finishes on its own.
  always @(posedge clk) begin
    en_d1 <= uart_tx_en;
    if (en_d1) begin
      busy <= 1'b1;
      bcnt <= BUSY_LEN - 1;
    end else if (busy) begin
      if (bcnt == 0) busy <= 1'b0;
      else           bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    req_valid[0]   = (q0.size() != 0);
    req_last[0]    = (q0.size() != 0) ? q0[0][8] : 1'b0;
    req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    req_valid[1]   = (q1.size() != 0);
    req_last[1]    = (q1.size() != 0) ? q1[0][8] : 1'b0;
    req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
  endtask

  // One clock: retire accepted bytes, log strobes, watch the busy window.
  task automatic step();
    logic [1:0] fire;
    logic [8:0] tmp;
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (fire[0]) tmp = q0.pop_front();
    if (fire[1]) tmp = q1.pop_front();
    present();
    if (uart_tx_en) txlog.push_back(uart_tx_data);
    if (timeout_pulse) n_pulse++;
    if (reset) hold_ok = 1'b0;
    else begin
      if (busy && !busy_prev) begin
        hold    = uart_tx_data;
        hold_ok = 1'b1;
      end
      if (busy && hold_ok) begin
        chk("en_while_busy", 32'(uart_tx_en), 32'd0);
        chk("data_stable_busy", 32'(uart_tx_data), 32'(hold));
      end
    end
    busy_prev = busy;
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    present();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k;
    k = 0;
    while (!(grant == 2'b00 && q0.size() == 0 && q1.size() == 0 && !busy && !uart_tx_en)
           && k < bound) begin
      step();
      k++;
    end
    chk(tag, 32'(k < bound), 32'd1);
  endtask

  // Wait for the granted requester 1 to re-enter FETCH after a byte.
  task automatic wait_fetch1(input string tag);
    int k;
    k = 0;
    while (!req_ready[1] && k < 400) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 400), 32'd1);
  endtask

  initial begin
    int b;
    int cnt;
    int p0;

    // Reset state
    present();
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_en", 32'(uart_tx_en), 32'd0);
    chk("rst_data", 32'(uart_tx_data), 32'd0);
    chk("rst_timeout", 32'(timeout_pulse), 32'd0);
    reset = 1'b0;

    // Single byte from requester 0: grant at t+1, en at t+2
    q0.push_back({1'b1, 8'h41});
    present();
    step();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_en_early", 32'(uart_tx_en), 32'd0);
    step();
    chk("single_en", 32'(uart_tx_en), 32'd1);
    chk("single_data", 32'(uart_tx_data), 32'h41);
    wait_idle("single_idle", 400);
    chk("single_count", 32'(txlog.size()), 32'd1);

    // Pointer now at 1: simultaneous requests go to requester 1 first
    q0.push_back({1'b1, 8'hC0});
    q1.push_back({1'b1, 8'hC1});
    present();
    step();
    chk("ptr_grant", 32'(grant), 32'h2);
    wait_idle("ptr_idle", 800);
    chk("ptr_count", 32'(txlog.size()), 32'd3);
    chk("ptr_first", 32'(txlog[1]), 32'hC1);
    chk("ptr_second", 32'(txlog[2]), 32'hC0);

    // Packet lock after reset: requester 0 keeps grant for its whole packet
    do_reset();
    b = txlog.size();
    q0.push_back({1'b0, 8'h10});
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b1, 8'h12});
    q1.push_back({1'b1, 8'h20});
    present();
    step();
    chk("lock_grant", 32'(grant), 32'h1);
    cnt = 0;
    while (!(grant == 2'b00 && q0.size() == 0 && q1.size() == 0 && !busy) && cnt < 2000) begin
      step();
      cnt++;
      if (grant == 2'b01) chk("lock_ready1", 32'(req_ready[1]), 32'd0);
    end
    chk("lock_idle", 32'(cnt < 2000), 32'd1);
    chk("lock_count", 32'(txlog.size() - b), 32'd4);
    chk("lock_b0", 32'(txlog[b]), 32'h10);
    chk("lock_b1", 32'(txlog[b+1]), 32'h11);
    chk("lock_b2", 32'(txlog[b+2]), 32'h12);
    chk("lock_b3", 32'(txlog[b+3]), 32'h20);

    // Fairness: alternating 1-byte packets, requester 0 first after reset
    do_reset();
    b = txlog.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'hA0});
      q1.push_back({1'b1, 8'hB0});
    end
    present();
    wait_idle("rr_idle", 2000);
    chk("rr_count", 32'(txlog.size() - b), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("rr_order", 32'(txlog[b+i]), (i % 2 == 0) ? 32'hA0 : 32'hB0);

    // Timeout: requester 1 sends non-last 0x55 then goes silent
    do_reset();
    b = txlog.size();
    q1.push_back({1'b0, 8'h55});
    present();
    step();
    chk("to_grant", 32'(grant), 32'h2);
    step();
    chk("to_en", 32'(uart_tx_en), 32'd1);
    chk("to_data", 32'(uart_tx_data), 32'h55);
    q0.push_back({1'b1, 8'h66});
    present();
    wait_fetch1("to_fetch");
    cnt = 0;
    while (!timeout_pulse && cnt < 200) begin
      step();
      cnt++;
    end
    chk("to_latency", 32'(cnt), 32'(TMO));
    chk("to_grant_clr", 32'(grant), 32'd0);
    step();
    chk("to_pulse_width", 32'(timeout_pulse), 32'd0);
    chk("to_next_grant", 32'(grant), 32'h1);
    wait_idle("to_idle", 800);
    chk("to_count", 32'(txlog.size() - b), 32'd2);
    chk("to_next_byte", 32'(txlog[b+1]), 32'h66);

    // Reset mid-packet (pointer is 1 here), asserted while in DRAIN
    q1.push_back({1'b0, 8'h31});
    q1.push_back({1'b1, 8'h32});
    present();
    cnt = 0;
    while (!uart_tx_en && cnt < 100) begin
      step();
      cnt++;
    end
    chk("mid_en_seen", 32'(cnt < 100), 32'd1);
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    present();
    step();
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_en", 32'(uart_tx_en), 32'd0);
    chk("mid_data", 32'(uart_tx_data), 32'd0);
    chk("mid_timeout", 32'(timeout_pulse), 32'd0);
    reset = 1'b0;
    cnt = 0;
    while (busy && cnt < 300) begin
      step();
      cnt++;
    end
    chk("mid_busy_done", 32'(cnt < 300), 32'd1);
    chk("mid_arb_idle", 32'(grant), 32'd0);
    b = txlog.size();
    q0.push_back({1'b1, 8'h61});
    q1.push_back({1'b1, 8'h62});
    present();
    step();
    chk("mid_ptr0_grant", 32'(grant), 32'h1);
    wait_idle("mid_idle", 800);
    chk("mid_first", 32'(txlog[b]), 32'h61);
    chk("mid_second", 32'(txlog[b+1]), 32'h62);

    // Byte arriving on the expiry cycle wins over the timeout
    do_reset();
    b = txlog.size();
    p0 = n_pulse;
    q1.push_back({1'b0, 8'h56});
    present();
    step();
    step();
    wait_fetch1("win_fetch");
    for (int i = 0; i < TMO - 1; i++) step();
    chk("win_still_fetch", 32'(req_ready), 32'h2);
    q1.push_back({1'b1, 8'h57});
    present();
    step();
    chk("win_en", 32'(uart_tx_en), 32'd1);
    chk("win_data", 32'(uart_tx_data), 32'h57);
    chk("win_no_pulse", 32'(timeout_pulse), 32'd0);
    wait_idle("win_idle", 800);
    chk("win_pulse_count", 32'(n_pulse - p0), 32'd0);
    chk("win_count", 32'(txlog.size() - b), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N byte-stream requesters, with round-robin arbitration at packet granularity. A requester keeps the grant until it delivers a byte flagged last, or until it stalls past a timeout. The block sits between on-chip producers (echo path, status reporter, debug dumper) and uart_tx in the board top. It owns the uart_tx_en / uart_tx_data / uart_tx_busy handshake.

Parameters:
N_REQ, 2, number of requesters (1..8)
PAYLOAD_BITS, 8, byte width; must match uart_tx
GUARD_CYCLES, 2, cycles after the uart_tx_en strobe during which uart_tx_busy is ignored (covers uart_tx busy-assert latency)
TIMEOUT_CYCLES, 1000000, FETCH cycles without req_valid before the grant is revoked; 0 disables the timeout

Ports:
clk  in  1  system clock (100 MHz sysclk2 domain)
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  N_REQ*PAYLOAD_BITS  requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
req_last  in  N_REQ  marks the final byte of a packet; qualified by valid
req_ready  out  N_REQ  byte accepted when valid&ready
uart_tx_en  out  1  one-cycle start strobe to uart_tx
uart_tx_data  out  PAYLOAD_BITS  byte to uart_tx; registered
uart_tx_busy  in  1  uart_tx is serializing
grant  out  N_REQ  one-hot current owner; all zero when idle
timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- During and after reset: state=ARB, rr pointer=0, grant=0, req_ready=0, uart_tx_en=0, uart_tx_data=0, timeout_pulse=0, counters=0.
- States:
  - ARB
    - if any req_valid: the first requester with valid set, searching from the rr pointer upward with wrap, is granted; grant registered; go to FETCH.
    - else stay.
  - FETCH
    - req_ready[g] = 1 (combinational, granted index only); all other req_ready = 0.
    - on req_valid[g]: latch req_data and req_last into uart_tx_data and last_q; clear the timeout counter; go to STROBE.
    - otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): timeout_pulse=1 for one cycle, grant=0, pointer=g+1 mod N_REQ, go to ARB.
  - STROBE: uart_tx_en=1 for exactly this cycle; go to GUARD.
  - GUARD: count GUARD_CYCLES cycles, then go to DRAIN; uart_tx_busy is ignored here.
  - DRAIN
    - wait for uart_tx_busy==0.
    - then if last_q: grant=0, pointer=g+1 mod N_REQ, go to ARB.
    - else go to FETCH.
- Latency:
  - req_valid seen in ARB at cycle t -> grant and req_ready at t+1 -> uart_tx_en at t+2.
  - Back-to-back bytes of one packet: next ready appears the cycle after busy falls, provided the guard period has elapsed.
- uart_tx_data holds stable from latch until the next latch; it is never changed while uart_tx is busy.
- Non-granted requesters see ready=0 and must hold their data. Their valid toggling has no effect.
- A new grant is taken only in ARB, never mid-packet. Simultaneous requests are resolved by the pointer alone.
- If the timeout expires in the same cycle req_valid[g] arrives, the byte wins: it is accepted and no timeout fires.
- N_REQ=1: pointer stays 0; behaviour is otherwise identical.
- Reset mid-packet: return to the reset state immediately and drop uart_tx_en. Any frame already inside uart_tx completes on its own.
- Counter widths: timeout counter $clog2(TIMEOUT_CYCLES+1), minimum 1; pointer $clog2(N_REQ), minimum 1.

Decomposition:
- Shared header uart_pkg.vh holds:
  - state encodings ARB/FETCH/STROBE/GUARD/DRAIN as localparams
  - default PAYLOAD_BITS, CLK_HZ and BIT_RATE, reused by uart_rx, uart_tx and the tops.
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs are req[N_REQ] and ptr. Outputs are a one-hot pick and an any flag. It is unit-testable on its own.

Test Plan:
- Single byte: requester 0 sends 0x41 with last=1.
  - Expect uart_tx_en 2 cycles after valid, uart_tx_data=0x41.
  - grant returns to 0 after busy falls.
- Packet lock: requester 0 sends 0x10,0x11,0x12(last) while requester 1 holds valid with 0x20(last).
  - Expect TX order 0x10,0x11,0x12,0x20.
  - req_ready[1]=0 throughout requester 0's packet.
- Round-robin fairness: both requesters continuously send 1-byte packets 0xA0 and 0xB0.
  - Expect strict alternation A0,B0,A0,B0.
  - After reset, requester 0 goes first.
- Timeout: TIMEOUT_CYCLES=50; requester 1 sends 0x55 (last=0) then drops valid.
  - Expect timeout_pulse exactly 50 FETCH cycles later and grant=0.
  - Requester 0's pending packet is then granted next.
- Busy model: the uart_tx model asserts busy 2 cycles after en and holds it for 100 cycles.
  - Expect exactly one uart_tx_en per byte, none while busy.
  - uart_tx_data is stable during busy.
- Reset mid-packet: assert reset while in DRAIN.
  - Expect all outputs 0 on the next cycle and state ARB.
  - Expect the pointer back at 0.
